digit_stabilizer: RTL and testbench
===================================

DIGIT_STABILIZER -- requirements
Module: digit_stabilizer

Interface
REQ-001 Parameter CHG_W, default 8: width of the digit-change counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  block enable; low = no samples accepted, all state held.
REQ-005 pred_in  input  4  digit prediction from the upstream classifier stage; legal values 0..9.
REQ-006 pred_valid  input  1  pred_in is meaningful this cycle.
REQ-007 cfg_thresh  input  3  required consecutive matching samples N; 1..7 gives N=value, 0 gives N=8.
REQ-008 digit_out  output  4  last locked (stable) digit.
REQ-009 digit_valid  output  1  a digit has been locked since reset.
REQ-010 seg_out  output  7  7-segment pattern of digit_out, active-high, bit order {g,f,e,d,c,b,a}.
REQ-011 change_pulse  output  1  one-cycle pulse on each locked-digit change.
REQ-012 change_count  output  CHG_W  number of locked-digit changes since reset.

Function
REQ-013 Sample accepted only on an edge where ena=1 and pred_valid=1; otherwise state, candidate, run count and outputs hold (change_pulse returns to 0).
REQ-014 Accepted sample with pred_in>9 is illegal: FSM to IDLE, run count to 0, digit_out/digit_valid/change_count held.
REQ-015 FSM states: IDLE (no candidate), TRACK (candidate held, run<N), LOCKED (candidate equals digit_out).
REQ-016 IDLE + legal sample d: candidate=d, run=1; go TRACK, or lock immediately if N=1.
REQ-017 TRACK + sample equal to candidate: run+1; if run+1>=N then lock, else stay TRACK.
REQ-018 TRACK or LOCKED + legal sample differing from candidate: candidate=new value, run=1, go TRACK (or lock if N=1); digit_out held meanwhile.
REQ-019 LOCKED + matching sample: stay LOCKED; run count saturates at 8 (3-bit plus saturation, never wraps).
REQ-020 Lock action, on the edge accepting the qualifying sample: digit_out<=candidate, digit_valid<=1, state LOCKED; latency zero cycles beyond that edge.
REQ-021 change_pulse=1 for exactly the cycle after a lock where digit_valid was 0 or candidate differed from previous digit_out; relocking the same digit gives no pulse.
REQ-022 change_count increments with each change_pulse; wraps from 2^CHG_W-1 to 0.
REQ-023 cfg_thresh evaluated at every accepted sample; a mid-run change applies immediately (run>=new N on a match locks).
REQ-024 seg_out combinational from registered digit_out/digit_valid: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex); 00 when digit_valid=0.
REQ-025 pred_valid high with ena low is ignored entirely.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, candidate 0, run 0, digit_out 0, digit_valid 0, change_pulse 0, change_count 0, hence seg_out 00.
REQ-027 Reset asserted mid-run discards partial run; first accepted sample after release starts a new run from IDLE.
REQ-028 Release of rst_n has no effect until the next rising clk edge.

Verification
REQ-029 cfg_thresh=3, samples 5,5,5 -> after third edge digit_out=5, digit_valid=1, seg_out=6D, change_pulse one cycle, change_count=1.
REQ-030 cfg_thresh=3, locked on 5, samples 7,7,2,2,2 -> digit_out stays 5 through the 7s, becomes 2 after fifth edge, change_count=2.
REQ-031 cfg_thresh=0, seven 4s then 12 then eight 4s -> no lock until 8th 4 after the 12; digit_out=4.
REQ-032 Locked on 3, cfg_thresh=2, samples 3,3 -> no change_pulse, change_count unchanged; ena=0 with pred_valid=1 and pred_in=8 for 10 cycles -> no state change.
REQ-033 cfg_thresh=1, 256 alternating samples 1,2 -> change_pulse every cycle, change_count wraps to 0 (CHG_W=8).
REQ-034 Two matching samples of 6 with cfg_thresh=3, rst_n pulsed low between clock edges -> all outputs 0 immediately; next single 6 does not lock.

Source files
------------

// File: rtl/digit_stabilizer.sv
// ============================================================================
// digit_stabilizer : locks a classifier digit after N consecutive matches. Rev 1.0
// ============================================================================
`default_nettype none

module digit_stabilizer #(
   parameter int CHG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [3:0]       pred_in,
   input  logic             pred_valid,
   input  logic [2:0]       cfg_thresh,
   output logic [3:0]       digit_out,
   output logic             digit_valid,
   output logic [6:0]       seg_out,
   output logic             change_pulse,
   output logic [CHG_W-1:0] change_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TRACK  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] cand;
   logic [3:0] run;

   logic       accept;
   logic       legal;
   logic       match;
   logic       lock;
   logic [3:0] need;
   logic [3:0] run_inc;

   always_comb begin
      accept  = ena & pred_valid;
      legal   = (pred_in <= 4'd9);
      need    = (cfg_thresh == 3'd0) ? 4'd8 : {1'b0, cfg_thresh};
      run_inc = (run >= 4'd8) ? 4'd8 : run + 4'd1;
      match   = (state != S_IDLE) && (pred_in == cand);
      // A match while already LOCKED never relocks; a fresh run locks only when N is 1.
      lock    = 1'b0;
      if (accept && legal) begin
         if (match)
            lock = (state == S_TRACK) && (run_inc >= need);
         else
            lock = (need == 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cand         <= 4'd0;
         run          <= 4'd0;
         digit_out    <= 4'd0;
         digit_valid  <= 1'b0;
         change_pulse <= 1'b0;
         change_count <= '0;
      end else begin
         change_pulse <= 1'b0;
         if (accept) begin
            if (!legal) begin
               state <= S_IDLE;
               run   <= 4'd0;
            end else if (match) begin
               run <= run_inc;
            end else begin
               cand  <= pred_in;
               run   <= 4'd1;
               state <= S_TRACK;
            end

            if (lock) begin
               state       <= S_LOCKED;
               digit_out   <= pred_in;
               digit_valid <= 1'b1;
               if (!digit_valid || (pred_in != digit_out)) begin
                  change_pulse <= 1'b1;
                  change_count <= change_count + {{(CHG_W-1){1'b0}}, 1'b1};
               end
            end
         end
      end
   end

   always_comb begin
      seg_out = 7'h00;
      if (digit_valid) begin
         case (digit_out)
            4'd0:    seg_out = 7'h3F;
            4'd1:    seg_out = 7'h06;
            4'd2:    seg_out = 7'h5B;
            4'd3:    seg_out = 7'h4F;
            4'd4:    seg_out = 7'h66;
            4'd5:    seg_out = 7'h6D;
            4'd6:    seg_out = 7'h7D;
            4'd7:    seg_out = 7'h07;
            4'd8:    seg_out = 7'h7F;
            4'd9:    seg_out = 7'h6F;
            default: seg_out = 7'h00;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_digit_stabilizer.sv
// ============================================================================
// tb_digit_stabilizer : directed + random checks against a run-length model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_digit_stabilizer;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [3:0] pred_in;
   logic       pred_valid;
   logic [2:0] cfg_thresh;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic [6:0] seg_out;
   logic       change_pulse;
   logic [7:0] change_count;

   digit_stabilizer #(.CHG_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .pred_in      (pred_in),
      .pred_valid   (pred_valid),
      .cfg_thresh   (cfg_thresh),
      .digit_out    (digit_out),
      .digit_valid  (digit_valid),
      .seg_out      (seg_out),
      .change_pulse (change_pulse),
      .change_count (change_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Reference model: length of the current run of identical legal samples,
   // and whether that run has already produced a lock.
   int  m_run_len;
   int  m_run_digit;
   bit  m_run_locked;
   int  m_digit;
   bit  m_valid;
   bit  m_pulse;
   int  m_count;

   task automatic model_reset();
      m_run_len = 0; m_run_digit = 0; m_run_locked = 0;
      m_digit = 0; m_valid = 0; m_pulse = 0; m_count = 0;
   endtask

   task automatic model_step(input bit e, input bit v, input int d, input int th);
      int n;
      m_pulse = 0;
      if (e && v) begin
         n = (th == 0) ? 8 : th;
         if (d > 9) begin
            m_run_len = 0;
            m_run_locked = 0;
         end else begin
            if (m_run_len > 0 && d == m_run_digit) begin
               m_run_len++;
            end else begin
               m_run_digit = d;
               m_run_len = 1;
               m_run_locked = 0;
            end
            if (!m_run_locked && m_run_len >= n) begin
               m_run_locked = 1;
               if (!m_valid || d != m_digit) begin
                  m_pulse = 1;
                  m_count = (m_count + 1) % 256;
               end
               m_digit = d;
               m_valid = 1;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [6:0] exp_seg;
      exp_seg = m_valid ? seg_tbl[m_digit] : 7'h00;
      check({tag, ".digit"}, 32'(digit_out), 32'(m_digit));
      check({tag, ".valid"}, 32'(digit_valid), 32'(m_valid));
      check({tag, ".seg"}, 32'(seg_out), 32'(exp_seg));
      check({tag, ".pulse"}, 32'(change_pulse), 32'(m_pulse));
      check({tag, ".count"}, 32'(change_count), 32'(m_count));
   endtask

   task automatic step(input string tag, input bit e, input bit v, input int d, input int th);
      ena = e; pred_valid = v; pred_in = 4'(d); cfg_thresh = 3'(th);
      @(posedge clk);
      model_step(e, v, d, th);
      #1;
      check_all(tag);
   endtask

   // Reset pulsed between clock edges; outputs must clear without a clock edge.
   task automatic mid_reset(input string tag);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all(tag);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int d;
      int th;
      rst_n = 1'b0; ena = 1'b0; pred_valid = 1'b0; pred_in = 4'd0; cfg_thresh = 3'd3;
      model_reset();
      #1 check_all("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // Lock on 5 with N=3, then a change to 2 through a pair of 7s.
      step("s5a", 1, 1, 5, 3);
      step("s5b", 1, 1, 5, 3);
      step("s5c", 1, 1, 5, 3);
      check("lock5_seg", 32'(seg_out), 32'h6D);
      check("lock5_pulse", 32'(change_pulse), 32'd1);
      step("idle1", 0, 0, 0, 3);
      check("pulse_one_cycle", 32'(change_pulse), 32'd0);
      step("s7a", 1, 1, 7, 3);
      step("s7b", 1, 1, 7, 3);
      step("s2a", 1, 1, 2, 3);
      step("s2b", 1, 1, 2, 3);
      step("s2c", 1, 1, 2, 3);
      check("lock2_digit", 32'(digit_out), 32'd2);
      check("lock2_count", 32'(change_count), 32'd2);

      // N=8: an illegal sample breaks a run of seven 4s.
      for (int i = 0; i < 7; i++) step("n8_pre", 1, 1, 4, 0);
      step("illegal", 1, 1, 12, 0);
      for (int i = 0; i < 8; i++) step("n8_post", 1, 1, 4, 0);
      check("n8_digit", 32'(digit_out), 32'd4);

      // Relock of the same digit gives no pulse; disabled samples are ignored.
      for (int i = 0; i < 2; i++) step("lock3", 1, 1, 3, 2);
      step("break3", 1, 1, 9, 2);
      step("relock3a", 1, 1, 3, 2);
      step("relock3b", 1, 1, 3, 2);
      step("relock3c", 1, 1, 3, 2);
      for (int i = 0; i < 10; i++) step("ena_low", 0, 1, 8, 2);
      check("ena_low_digit", 32'(digit_out), 32'd3);

      // Mid-run threshold drop locks on the next match.
      step("thr_a", 1, 1, 6, 7);
      step("thr_b", 1, 1, 6, 7);
      step("thr_c", 1, 1, 6, 2);
      check("thr_drop_digit", 32'(digit_out), 32'd6);

      // N=1 alternating digits: pulse every cycle, counter wraps.
      mid_reset("rst_wrap");
      for (int i = 0; i < 256; i++) step("alt", 1, 1, (i % 2 == 0) ? 1 : 2, 1);
      check("wrap_count", 32'(change_count), 32'd0);

      // Reset in the middle of a run discards it.
      mid_reset("rst_pre6");
      step("r6a", 1, 1, 6, 3);
      step("r6b", 1, 1, 6, 3);
      mid_reset("rst_mid6");
      check("rst_seg", 32'(seg_out), 32'h00);
      step("r6c", 1, 1, 6, 3);
      check("r6_nolock", 32'(digit_valid), 32'd0);

      // Randomized traffic.
      d = 0; th = 3;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) th = $urandom_range(0, 7);
         if ($urandom_range(0, 2) == 0) begin
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         end
         if ($urandom_range(0, 150) == 0) mid_reset("rnd_rst");
         step("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), d, th);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
